// File: rtl/divider_pipe.sv
// Fully pipelined restoring divider: one unsigned dividend/divisor pair per pixelclk, with hs/vs/de aligned to the result.
// Optional: define DIVIDER_PIPE_ROUND_EN for a round-half-up quotient (adds one register stage).
module divider_pipe #(
    parameter int N = 24,
    parameter int F = 0
) (
    input  logic             pixelclk,
    input  logic             rst,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic             i_de,
    input  logic [N-1:0]     dividend,
    input  logic [N-1:0]     divisor,
    output logic [N+F-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             o_dz,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de
);
    localparam int Q = N + F;

    logic [N-1:0] rem_p [Q];
    logic [N-1:0] dvd_p [Q];
    logic [N-1:0] div_p [Q];
    logic [Q-1:0] quo_p [Q];
    logic         dz_p  [Q];
    logic         vld_p [Q];
    logic         hs_p  [Q];
    logic         vs_p  [Q];

    for (genvar k = 0; k < Q; k++) begin : g_stage
        logic [N-1:0] rem_in, dvd_in, div_in, diff;
        logic [Q-1:0] quo_in;
        logic         dz_in, vld_in, hs_in, vs_in, nbit, ge;
        logic [N:0]   trial;

        if (k == 0) begin : g_head
            assign rem_in = '0;
            assign dvd_in = dividend;
            assign div_in = divisor;
            assign quo_in = '0;
            assign dz_in  = (divisor == '0);
            assign vld_in = i_de;
            assign hs_in  = i_hs;
            assign vs_in  = i_vs;
        end else begin : g_body
            assign rem_in = rem_p[k-1];
            assign dvd_in = dvd_p[k-1];
            assign div_in = div_p[k-1];
            assign quo_in = quo_p[k-1];
            assign dz_in  = dz_p[k-1];
            assign vld_in = vld_p[k-1];
            assign hs_in  = hs_p[k-1];
            assign vs_in  = vs_p[k-1];
        end

        // Numerator is dividend << F, so the last F stages shift in zeros.
        if (k < N) begin : g_int
            assign nbit = dvd_in[N-1-k];
        end else begin : g_frac
            assign nbit = 1'b0;
        end

        // The partial remainder stays below the divisor, so the N-bit modular difference is exact when ge.
        assign trial = {rem_in, nbit};
        assign ge    = (trial >= {1'b0, div_in});
        assign diff  = trial[N-1:0] - div_in;

        always_ff @(posedge pixelclk) begin
            if (rst) begin
                rem_p[k] <= '0;
                dvd_p[k] <= '0;
                div_p[k] <= '0;
                quo_p[k] <= '0;
                dz_p[k]  <= 1'b0;
                vld_p[k] <= 1'b0;
                hs_p[k]  <= 1'b0;
                vs_p[k]  <= 1'b0;
            end else begin
                rem_p[k] <= ge ? diff : trial[N-1:0];
                dvd_p[k] <= dvd_in;
                div_p[k] <= div_in;
                quo_p[k] <= quo_in | ({{(Q-1){1'b0}}, ge} << (Q - 1 - k));
                dz_p[k]  <= dz_in;
                vld_p[k] <= vld_in;
                hs_p[k]  <= hs_in;
                vs_p[k]  <= vs_in;
            end
        end
    end

    logic [Q-1:0] fin_q;
    logic [N-1:0] fin_r;
    logic         fin_dz, fin_vld, fin_hs, fin_vs;

`ifdef DIVIDER_PIPE_ROUND_EN
    function automatic logic [Q-1:0] round_sat(input logic [Q-1:0] q,
                                              input logic [N-1:0] r,
                                              input logic [N-1:0] d);
        logic [N:0] twice_r;
        twice_r = {r, 1'b0};
        if ((twice_r >= {1'b0, d}) && (q != '1))
            return q + 1'b1;
        return q;
    endfunction

    logic [Q-1:0] rq_p;
    logic [N-1:0] rr_p;
    logic         rdz_p, rvld_p, rhs_p, rvs_p;

    // Rounding stage: divide-by-zero results bypass rounding.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            rq_p   <= '0;
            rr_p   <= '0;
            rdz_p  <= 1'b0;
            rvld_p <= 1'b0;
            rhs_p  <= 1'b0;
            rvs_p  <= 1'b0;
        end else begin
            rq_p   <= dz_p[Q-1] ? '1 : round_sat(quo_p[Q-1], rem_p[Q-1], div_p[Q-1]);
            rr_p   <= dz_p[Q-1] ? dvd_p[Q-1] : rem_p[Q-1];
            rdz_p  <= dz_p[Q-1];
            rvld_p <= vld_p[Q-1];
            rhs_p  <= hs_p[Q-1];
            rvs_p  <= vs_p[Q-1];
        end
    end

    assign fin_q   = rq_p;
    assign fin_r   = rr_p;
    assign fin_dz  = rdz_p;
    assign fin_vld = rvld_p;
    assign fin_hs  = rhs_p;
    assign fin_vs  = rvs_p;
`else
    assign fin_q   = dz_p[Q-1] ? '1 : quo_p[Q-1];
    assign fin_r   = dz_p[Q-1] ? dvd_p[Q-1] : rem_p[Q-1];
    assign fin_dz  = dz_p[Q-1];
    assign fin_vld = vld_p[Q-1];
    assign fin_hs  = hs_p[Q-1];
    assign fin_vs  = vs_p[Q-1];
`endif

    // Output stage: results hold across de=0 gaps, syncs follow every cycle.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            o_dz      <= 1'b0;
            o_hsync   <= 1'b0;
            o_vsync   <= 1'b0;
            o_de      <= 1'b0;
        end else begin
            o_hsync <= fin_hs;
            o_vsync <= fin_vs;
            o_de    <= fin_vld;
            if (fin_vld) begin
                quotient  <= fin_q;
                remainder <= fin_r;
                o_dz      <= fin_dz;
            end
        end
    end

endmodule

// File: tb/tb_divider_pipe.sv
// Directed bench for divider_pipe: integer (F=0) and fractional (F=8) instances share the input stream.
module tb_divider_pipe;
    localparam int N = 24;
`ifdef DIVIDER_PIPE_ROUND_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int L0 = N + 0 + 1 + EXTRA;
    localparam int L8 = N + 8 + 1 + EXTRA;
    localparam int NB = 640;

    logic          pixelclk, rst, i_hs, i_vs, i_de;
    logic [N-1:0]  dividend, divisor;
    logic [N-1:0]  q0, r0, r8;
    logic [N+7:0]  q8;
    logic          dz0, hs0, vs0, de0, dz8, hs8, vs8, de8;

    int n_checks = 0;
    int n_fail   = 0;

    divider_pipe #(.N(N), .F(0)) dut (
        .pixelclk(pixelclk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
        .dividend(dividend), .divisor(divisor), .quotient(q0), .remainder(r0),
        .o_dz(dz0), .o_hsync(hs0), .o_vsync(vs0), .o_de(de0)
    );

    divider_pipe #(.N(N), .F(8)) dut8 (
        .pixelclk(pixelclk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
        .dividend(dividend), .divisor(divisor), .quotient(q8), .remainder(r8),
        .o_dz(dz8), .o_hsync(hs8), .o_vsync(vs8), .o_de(de8)
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    task automatic step();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic drive(input logic de, input logic [N-1:0] a, input logic [N-1:0] b);
        i_de     = de;
        dividend = a;
        divisor  = b;
    endtask

    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic dz);
        logic [N:0] r2;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
`ifdef DIVIDER_PIPE_ROUND_EN
            r2 = {1'b0, r} * 2;
            if (r2 >= {1'b0, b} && q != {N{1'b1}}) q = q + 1;
`else
            r2 = '0;
`endif
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_hs = 1'b0; i_vs = 1'b0;
        drive(1'b0, '0, '0);
        repeat (3) step();
        n_checks++; if (q0 !== 24'd0) begin n_fail++; $display("FAIL reset_quotient: got %0h want 0", q0); end
        n_checks++; if (r0 !== 24'd0) begin n_fail++; $display("FAIL reset_remainder: got %0h want 0", r0); end
        n_checks++; if (dz0 !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", dz0); end
        n_checks++; if (de0 !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", de0); end
        n_checks++; if (hs0 !== 1'b0 || vs0 !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b want 0", hs0, vs0); end
        n_checks++; if (q8 !== 32'd0 || de8 !== 1'b0) begin n_fail++; $display("FAIL reset_frac: got q=%0h de=%b want 0", q8, de8); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        drive(1'b1, 24'd100, 24'd7);
        step();
        drive(1'b0, '0, '0);
        repeat (L0 - 2) step();
        n_checks++; if (de0 !== 1'b0) begin n_fail++; $display("FAIL basic_early_de: got %b want 0", de0); end
        step();
        n_checks++; if (de0 !== 1'b1) begin n_fail++; $display("FAIL basic_de: got %b want 1", de0); end
        n_checks++; if (q0 !== 24'd14) begin n_fail++; $display("FAIL basic_quotient: got %0d want 14", q0); end
        n_checks++; if (r0 !== 24'd2) begin n_fail++; $display("FAIL basic_remainder: got %0d want 2", r0); end
        n_checks++; if (dz0 !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", dz0); end
        step();
        n_checks++; if (de0 !== 1'b0) begin n_fail++; $display("FAIL basic_de_pulse: got %b want 0", de0); end
        n_checks++; if (q0 !== 24'd14 || r0 !== 24'd2) begin n_fail++; $display("FAIL basic_hold: got q=%0d r=%0d want 14/2", q0, r0); end
    endtask

    task automatic test_fractional();
        drive(1'b1, 24'd1, 24'd3);         step();
        drive(1'b1, 24'd3, 24'd2);         step();
        drive(1'b1, 24'hFFFFFF, 24'd1);    step();
        drive(1'b0, '0, '0);
        repeat (L8 - 3) step();
        n_checks++; if (de8 !== 1'b1) begin n_fail++; $display("FAIL frac_de: got %b want 1", de8); end
        n_checks++; if (q8 !== 32'h55 || r8 !== 24'd1) begin n_fail++; $display("FAIL frac_1_3: got q=%0h r=%0h want 55/1", q8, r8); end
        step();
        n_checks++; if (q8 !== 32'h180 || r8 !== 24'd0) begin n_fail++; $display("FAIL frac_3_2: got q=%0h r=%0h want 180/0", q8, r8); end
        step();
        n_checks++; if (q8 !== 32'hFFFFFF00 || r8 !== 24'd0) begin n_fail++; $display("FAIL frac_fullscale: got q=%0h r=%0h want ffffff00/0", q8, r8); end
        step();
        n_checks++; if (de8 !== 1'b0 || q8 !== 32'hFFFFFF00) begin n_fail++; $display("FAIL frac_hold: got de=%b q=%0h want 0/ffffff00", de8, q8); end
    endtask

    task automatic test_div_zero();
        drive(1'b1, 24'h00ABCD, 24'd0);  step();
        drive(1'b1, 24'd10, 24'd5);      step();
        drive(1'b0, '0, '0);
        repeat (L0 - 2) step();
        n_checks++; if (q0 !== 24'hFFFFFF) begin n_fail++; $display("FAIL dz_quotient: got %0h want ffffff", q0); end
        n_checks++; if (r0 !== 24'h00ABCD) begin n_fail++; $display("FAIL dz_remainder: got %0h want abcd", r0); end
        n_checks++; if (dz0 !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", dz0); end
        step();
        n_checks++; if (q0 !== 24'd2 || r0 !== 24'd0) begin n_fail++; $display("FAIL dz_next: got q=%0d r=%0d want 2/0", q0, r0); end
        n_checks++; if (dz0 !== 1'b0) begin n_fail++; $display("FAIL dz_next_flag: got %b want 0", dz0); end
    endtask

`ifdef DIVIDER_PIPE_ROUND_EN
    task automatic test_round();
        drive(1'b1, 24'd100, 24'd8);     step();
        drive(1'b1, 24'hFFFFFF, 24'd1);  step();
        drive(1'b1, 24'd99, 24'd8);      step();
        drive(1'b0, '0, '0);
        repeat (L0 - 4) step();
        n_checks++; if (de0 !== 1'b0) begin n_fail++; $display("FAIL round_early_de: got %b want 0", de0); end
        step();
        n_checks++; if (de0 !== 1'b1 || q0 !== 24'd13) begin n_fail++; $display("FAIL round_100_8: got de=%b q=%0d want 1/13", de0, q0); end
        n_checks++; if (r0 !== 24'd4) begin n_fail++; $display("FAIL round_rem: got %0d want 4", r0); end
        step();
        n_checks++; if (q0 !== 24'hFFFFFF) begin n_fail++; $display("FAIL round_sat: got %0h want ffffff", q0); end
        step();
        n_checks++; if (q0 !== 24'd12) begin n_fail++; $display("FAIL round_99_8: got %0d want 12", q0); end
    endtask
`endif

    task automatic test_reset_mid();
        bit saw_de;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 24'd1000 + 24'(i), 24'd3);
            step();
        end
        rst = 1'b1;
        drive(1'b1, 24'd5, 24'd1);
        step();
        n_checks++; if (q0 !== 24'd0 || r0 !== 24'd0 || dz0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_data: got q=%0h r=%0h dz=%b want 0", q0, r0, dz0); end
        n_checks++; if (de0 !== 1'b0 || hs0 !== 1'b0 || vs0 !== 1'b0 || de8 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got de=%b hs=%b vs=%b de8=%b want 0", de0, hs0, vs0, de8); end
        rst = 1'b0;
        drive(1'b0, '0, '0);
        saw_de = 1'b0;
        for (int i = 0; i < L8 + 2; i++) begin
            step();
            if (de0 || de8) saw_de = 1'b1;
        end
        n_checks++; if (saw_de !== 1'b0) begin n_fail++; $display("FAIL rstmid_leak: got de pulse 1 want 0"); end
        drive(1'b1, 24'd50, 24'd7);
        step();
        drive(1'b0, '0, '0);
        repeat (L0 - 2) step();
        n_checks++; if (de0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_early: got %b want 0", de0); end
        step();
        n_checks++; if (de0 !== 1'b1 || q0 !== 24'd7 || r0 !== 24'd1) begin n_fail++; $display("FAIL rstmid_first: got de=%b q=%0d r=%0d want 1/7/1", de0, q0, r0); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] va [NB];
        logic [N-1:0] vb [NB];
        logic         vde [NB];
        logic         vhs [NB];
        logic         vvs [NB];
        logic [N-1:0] eq, er;
        logic         edz, xde, xhs, xvs, have;
        int           j;
        for (int c = 0; c < NB; c++) begin
            va[c]  = 24'($urandom);
            case ($urandom_range(0, 7))
                0:       vb[c] = '0;
                1, 2:    vb[c] = 24'($urandom_range(1, 255));
                default: vb[c] = 24'($urandom);
            endcase
            vde[c] = (c == 0) || ($urandom_range(0, 4) != 0);
            vhs[c] = (c % 40) < 4;
            vvs[c] = (c % 320) < 2;
        end
        have = 1'b0; eq = '0; er = '0; edz = 1'b0;
        for (int c = 0; c < NB + L0; c++) begin
            if (c < NB) begin
                drive(vde[c], va[c], vb[c]); i_hs = vhs[c]; i_vs = vvs[c];
            end else begin
                drive(1'b0, '0, '0); i_hs = 1'b0; i_vs = 1'b0;
            end
            step();
            j = c - L0 + 1;
            if (j >= 0) begin
                xde = (j < NB) ? vde[j] : 1'b0;
                xhs = (j < NB) ? vhs[j] : 1'b0;
                xvs = (j < NB) ? vvs[j] : 1'b0;
                n_checks++; if (de0 !== xde || hs0 !== xhs || vs0 !== xvs) begin n_fail++; $display("FAIL b2b_sync[%0d]: got de=%b hs=%b vs=%b want %b/%b/%b", j, de0, hs0, vs0, xde, xhs, xvs); end
                if (j < NB && vde[j]) begin
                    model(va[j], vb[j], eq, er, edz);
                    have = 1'b1;
                end
                if (have) begin
                    n_checks++; if (q0 !== eq || r0 !== er || dz0 !== edz) begin n_fail++; $display("FAIL b2b_data[%0d]: got q=%0h r=%0h dz=%b want %0h/%0h/%b", j, q0, r0, dz0, eq, er, edz); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fractional();
        test_div_zero();
`ifdef DIVIDER_PIPE_ROUND_EN
        test_round();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_pipe.md
Name: divider_pipe

Overview:
- Fully pipelined restoring divider for the ISP pixel stream. Accepts one dividend/divisor pair per pixelclk and produces one quotient/remainder per clock.
- Successor to the single-shot iterative divider. Adds:
  - parametrised operand width
  - optional fractional quotient bits (for hue/ratio maths)
  - sync-aligned hs/vs/de outputs
  - divide-by-zero flagging
- Sits between colour-space stages and threshold/classification logic.

Parameters:
- N, 24, operand width (dividend, divisor, remainder)
- F, 0, fractional quotient bits; quotient width is N+F
- Q (localparam), N+F, number of quotient-bit stages
- L (localparam), Q+1, input-to-output latency in cycles

Ports:
- pixelclk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- i_hs  in  1  line sync, delayed with data
- i_vs  in  1  frame sync, delayed with data
- i_de  in  1  data enable; operands valid when 1
- dividend  in  N  unsigned dividend
- divisor  in  N  unsigned divisor
- quotient  out  N+F  unsigned quotient; binary point F bits from the LSB
- remainder  out  N  unsigned remainder, scaled by 2^F
- o_dz  out  1  divide-by-zero flag for the current output pixel
- o_hsync  out  1  i_hs delayed by L
- o_vsync  out  1  i_vs delayed by L
- o_de  out  1  i_de delayed by L

Behaviour:
- One clock domain, pixelclk. Reset is synchronous and active-high: rst sampled high at a rising edge clears every pipeline register.
- Reset values: quotient=0, remainder=0, o_dz=0, o_hsync=0, o_vsync=0, o_de=0.
- No backpressure. The pipeline advances every cycle and a new operand pair may enter every cycle, regardless of i_de.
- Latency: operands sampled at edge t appear on the outputs after edge t+L (L=N+F+1). Throughput is 1 per clock.
- hs/vs/de travel in a shift chain of exactly L stages alongside the data; no skew between data and syncs.
- Arithmetic:
  - Working numerator = dividend shifted left by F, i.e. Q bits.
  - Partial remainder is N+1 bits internally, so no overflow at the comparison.
  - Stage k (k=0..Q-1) brings in numerator bit Q-1-k: r' = {r, bit}.
  - If r' >= divisor: subtract divisor and set quotient bit Q-1-k to 1. Otherwise pass r' and set the bit to 0.
  - Final remainder is < divisor and fits in N bits.
- Divide by zero (divisor==0 at capture):
  - quotient = all ones
  - remainder = dividend[N-1:0]
  - o_dz=1 at the output
  - The zero divisor is tracked per pixel through the pipe, not recomputed at the output.
- Output hold:
  - quotient/remainder/o_dz register updates only when the final-stage de is 1.
  - When o_de=0 they hold the last valid pixel's values (0 after reset).
  - o_hsync/o_vsync/o_de update every cycle.
- Reset mid-operation:
  - All in-flight pixels are discarded.
  - o_de stays 0 for L cycles after rst deasserts, and until the first post-reset i_de pixel arrives.
  - No partial results escape.
- Simultaneous i_de=1 and rst=1: reset wins; that pixel is lost.
- Full-scale: dividend=2^N-1, divisor=1 gives quotient=(2^N-1)<<F, remainder=0. No saturation is needed in the truncating mode.

Optional Feature:
- Macro: DIVIDER_PIPE_ROUND_EN.
- Defined:
  - Quotient is rounded to nearest, half up: +1 LSB when 2*remainder >= divisor.
  - Rounding saturates at all ones.
  - Remainder output is the pre-rounding value.
  - One extra register stage is added, so L=N+F+2; sync chains lengthen to match.
  - The divide-by-zero result is not rounded.
- Undefined: truncating quotient, L=N+F+1, no extra logic.

Test Plan:
- N=24, F=0: 100/7 with i_de=1 for one cycle -> quotient=14, remainder=2, o_de=1 exactly 25 cycles later, for one cycle.
- N=24, F=8: 1/3 -> quotient=0x55, remainder=1. Also 3/2 -> quotient=0x180, remainder=0.
- Divisor 0, dividend 0x00ABCD -> quotient=0xFFFFFF, remainder=0x00ABCD, o_dz=1. Next pixel 10/5 -> quotient=2, remainder=0, o_dz=0.
- Back-to-back burst of 640 random pairs with hs/vs toggling:
  - every result matches the reference model
  - o_hsync/o_vsync/o_de are identical to the inputs shifted by L
  - outputs hold their values during de=0 gaps
- Assert rst for 1 cycle with 10 pixels in flight -> all outputs 0 next edge; no o_de pulse until new input plus L.
- With DIVIDER_PIPE_ROUND_EN, N=24, F=0:
  - 100/8 -> quotient 13, L=26
  - 0xFFFFFF/1 -> quotient 0xFFFFFF (saturation)
  - 99/8 -> quotient 12
